regfile_mp: RTL

Parametrised multi-port integer register file for the RISC-V core, successor to the single-write, two-read register file. It adds configurable read/write port counts, per-register busy scoreboard for hazard detection, optional write-to-read bypass, asynchronous reset of all state, and a hardware dump sequencer. The dump sequencer streams the register contents over a valid/ready channel, replacing simulation-only printing. It sits between the decode stage (reads, issue) and the writeback stage (writes).

---
 rtl/riscv_structures.sv | 11 +
 rtl/regfile_wr_mux.sv | 34 +++
 rtl/regfile_mp.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_structures.sv
// Shared types and constants for the integer register file.
package riscv_structures;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } regfile_dump_state_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_wr_mux.sv
// Picks the read value for one address: x0 forces zero, else the highest-index matching
// enabled write (when bypassing), else the stored value. Purely combinational.
module regfile_wr_mux
    import riscv_structures::*;
#(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]       addr,
    input  logic [XLEN-1:0]     stored,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     data
);

    always_comb begin
        data = stored;
        if (BYPASS != 0) begin
            // Ascending scan so the highest-index matching port ends up selected.
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
                    data = wr_data[p*XLEN +: XLEN];
                end
            end
        end
        if (addr == AW'(REG_ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard, optional write bypass and a
// valid/ready dump sequencer that streams every register in index order.
module regfile_mp
    import riscv_structures::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                dump_req,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_last
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            // Later ports are scheduled last, so the highest-index port wins a collision.
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] != AW'(REG_ZERO))) begin
                    regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        busy_nxt = busy;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p]) begin
                busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        // Issue is applied after the clears so a same-cycle issue keeps the register busy.
        if (iss_en) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[i*AW +: AW];

        regfile_wr_mux #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_rd_mux (
            .addr    (addr),
            .stored  (regs[addr]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[i*XLEN +: XLEN])
        );

        assign rd_busy[i] = busy[addr];
    end

    regfile_dump_state_e state;
    logic [AW-1:0]       ld_addr;
    logic [XLEN-1:0]     ld_data;

    assign ld_addr    = (state == RUN) ? dump_idx + AW'(1) : AW'(REG_ZERO);
    assign dump_valid = (state == RUN);
    assign dump_last  = (state == RUN) && (dump_idx == AW'(NREGS - 1));

    // The dump load always forwards same-cycle writes, independent of BYPASS.
    regfile_wr_mux #(
        .XLEN   (XLEN),
        .AW     (AW),
        .NWR    (NWR),
        .BYPASS (1)
    ) u_dump_mux (
        .addr    (ld_addr),
        .stored  (regs[ld_addr]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dump_idx  <= '0;
            dump_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        state     <= RUN;
                        dump_idx  <= '0;
                        dump_data <= ld_data;
                    end
                end
                RUN: begin
                    if (dump_ready) begin
                        if (dump_last) begin
                            state    <= IDLE;
                            dump_idx <= '0;
                        end else begin
                            dump_idx  <= dump_idx + AW'(1);
                            dump_data <= ld_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
